// File: rtl/spi_frame_responder_if.sv
// ---------------------------------------------------------------------------
// spi_frame_responder_if
// Bundles the SPI pins and the tx/rx word handshake of spi_frame_responder.
//   slave  : the responder (drives MISO, rx side, tx_ready, status pulses)
//   master : the SPI controller / host logic around it
// Signals:
//   spi_sclk, spi_cs_n, spi_mosi  controller -> responder pins
//   spi_miso, spi_miso_oe         responder -> controller pin and its enable
//   tx_data/tx_valid/tx_ready     next response frame handshake
//   rx_data/rx_valid              last complete MOSI frame
//   frame_error, tx_underrun      1-cycle status pulses
//   bit_count                     bits sampled in the current frame
// ---------------------------------------------------------------------------
interface spi_frame_responder_if #(
    parameter int FRAME_BITS = 32
);
    logic                              spi_sclk;
    logic                              spi_cs_n;
    logic                              spi_mosi;
    logic                              spi_miso;
    logic                              spi_miso_oe;
    logic [FRAME_BITS-1:0]             tx_data;
    logic                              tx_valid;
    logic                              tx_ready;
    logic [FRAME_BITS-1:0]             rx_data;
    logic                              rx_valid;
    logic                              frame_error;
    logic                              tx_underrun;
    logic [$clog2(FRAME_BITS+1)-1:0]   bit_count;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               frame_error, tx_underrun, bit_count
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               frame_error, tx_underrun, bit_count
    );
endinterface

// File: rtl/spi_frame_responder.sv
// ---------------------------------------------------------------------------
// spi_frame_responder
// SPI peripheral-side frame responder (CPOL=0, CPHA=1) used as a loopback /
// ADC stand-in. SCLK, CS_N and MOSI are oversampled in the input_clock
// domain; one FRAME_BITS-wide MOSI frame is captured per CS_N low window
// while a pre-loaded response word is shifted out on MISO, MSB first.
// Ports:
//   input_clock  system clock (>= 8x SCLK)
//   reset        synchronous, active-high
//   bus          spi_frame_responder_if.slave (pins + tx/rx handshake)
// ---------------------------------------------------------------------------
module spi_frame_responder #(
    parameter int                    FRAME_BITS   = 32,
    parameter logic [FRAME_BITS-1:0] DEFAULT_WORD = '0
) (
    input  logic                  input_clock,
    input  logic                  reset,
    spi_frame_responder_if.slave  bus
);
    localparam int             BW   = $clog2(FRAME_BITS + 1);
    localparam logic [BW-1:0]  FULL = BW'(FRAME_BITS);

    typedef enum logic [1:0] {RESYNC, IDLE, SHIFT, HOLD} state_t;

    // -----------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizers, history flops for edges.
    // -----------------------------------------------------------------------
    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       cs_hist, sclk_hist;

    always_ff @(posedge input_clock) begin
        if (reset) begin
            cs_sync   <= 2'b11;
            cs_hist   <= 1'b1;
            sclk_sync <= 2'b00;
            sclk_hist <= 1'b0;
            mosi_sync <= 2'b00;
        end else begin
            cs_sync   <= {cs_sync[0], bus.spi_cs_n};
            cs_hist   <= cs_sync[1];
            sclk_sync <= {sclk_sync[0], bus.spi_sclk};
            sclk_hist <= sclk_sync[1];
            mosi_sync <= {mosi_sync[0], bus.spi_mosi};
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
    assign cs_fall   =  cs_hist   & ~cs_sync[1];
    assign cs_rise   = ~cs_hist   &  cs_sync[1];
    assign sclk_rise = ~sclk_hist &  sclk_sync[1];
    assign sclk_fall =  sclk_hist & ~sclk_sync[1];
    // MOSI goes through the same depth as SCLK, so it lines up with the
    // falling-edge event that samples it.
    assign mosi_s    = mosi_sync[1];

    // -----------------------------------------------------------------------
    // Frame state machine, tx holding buffer and registered outputs.
    // -----------------------------------------------------------------------
    state_t                state;
    logic [1:0]            settle;
    logic [FRAME_BITS-1:0] tx_buf, tx_sh, rx_sh, rx_word;
    logic                  buf_full;
    logic                  miso, miso_oe, rx_vld, frm_err, underrun;
    logic [BW-1:0]         bcnt;

    always_ff @(posedge input_clock) begin
        if (reset) begin
            state    <= RESYNC;
            settle   <= 2'd0;
            tx_buf   <= '0;
            buf_full <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_word  <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            rx_vld   <= 1'b0;
            frm_err  <= 1'b0;
            underrun <= 1'b0;
            bcnt     <= '0;
        end else begin
            rx_vld   <= 1'b0;
            frm_err  <= 1'b0;
            underrun <= 1'b0;

            // Accept only into an empty buffer; a load into the shift
            // register needs a full one, so the two never collide. A word
            // accepted on the frame-start cycle waits for the next frame.
            if (bus.tx_valid && !buf_full) begin
                tx_buf   <= bus.tx_data;
                buf_full <= 1'b1;
            end

            if (state != RESYNC && cs_rise) begin
                // CS_N release wins over any SCLK edge in the same cycle.
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                if (bcnt == FULL) begin
                    rx_word <= rx_sh;
                    rx_vld  <= 1'b1;
                end else begin
                    frm_err <= 1'b1;
                end
                bcnt  <= '0;
                state <= IDLE;
            end else begin
                case (state)
                    RESYNC: begin
                        // The synchronizers come out of reset reading
                        // cs_n=1; let real pin samples flush through before
                        // trusting that, so a mid-frame reset never rejoins.
                        if (settle != 2'd3)
                            settle <= settle + 2'd1;
                        else if (cs_sync[1])
                            state <= IDLE;
                    end
                    IDLE: begin
                        bcnt <= '0;
                        if (cs_fall) begin
                            if (buf_full) begin
                                tx_sh    <= tx_buf;
                                buf_full <= 1'b0;
                            end else begin
                                tx_sh    <= DEFAULT_WORD;
                                underrun <= 1'b1;
                            end
                            rx_sh   <= '0;
                            miso    <= 1'b0;
                            miso_oe <= 1'b1;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sclk_rise) begin
                            miso  <= tx_sh[FRAME_BITS-1];
                            tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                        end
                        if (sclk_fall) begin
                            rx_sh <= {rx_sh[FRAME_BITS-2:0], mosi_s};
                            bcnt  <= bcnt + BW'(1);
                            if (bcnt + BW'(1) == FULL) begin
                                // Last bit already sampled by the controller
                                // on this falling edge; park MISO low.
                                miso  <= 1'b0;
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.spi_miso    = miso;
    assign bus.spi_miso_oe = miso_oe;
    assign bus.tx_ready    = ~buf_full;
    assign bus.rx_data     = rx_word;
    assign bus.rx_valid    = rx_vld;
    assign bus.frame_error = frm_err;
    assign bus.tx_underrun = underrun;
    assign bus.bit_count   = bcnt;
endmodule

// File: tb/tb_spi_frame_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_responder
// Directed bench for spi_frame_responder: a bit-banged SPI controller
// (SCLK period = 10 input_clock cycles) with hand-computed expected words.
// ---------------------------------------------------------------------------
module tb_spi_frame_responder;
    localparam int FB = 32;
    localparam int H  = 5;   // SCLK half period in input_clock cycles

    logic input_clock = 1'b0;
    logic reset       = 1'b1;

    spi_frame_responder_if #(.FRAME_BITS(FB)) bus ();

    spi_frame_responder #(
        .FRAME_BITS   (FB),
        .DEFAULT_WORD ('0)
    ) dut (
        .input_clock (input_clock),
        .reset       (reset),
        .bus         (bus)
    );

    always #10 input_clock = ~input_clock;

    int n_chk = 0, n_err = 0;
    int n_rxv = 0, n_ferr = 0, n_und = 0;

    // Pulse counters; tests look at deltas across a frame.
    always @(negedge input_clock) begin
        if (bus.rx_valid)    n_rxv++;
        if (bus.frame_error) n_ferr++;
        if (bus.tx_underrun) n_und++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge input_clock);
    endtask

    task automatic load_tx(input logic [31:0] w);
        int t;
        t = 0;
        while (!bus.tx_ready && t < 50) begin
            cyc(1);
            t++;
        end
        chk("tx_ready_before_load", bus.tx_ready, 1);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        cyc(1);
        bus.tx_valid = 1'b0;
    endtask

    // Clock n SCLK cycles; MOSI changes on rise, MISO is read just before fall.
    task automatic clk_bits(input int n, input logic [63:0] mo,
                            output logic [63:0] mi, output int oe_hi);
        mi    = '0;
        oe_hi = 0;
        for (int i = 0; i < n; i++) begin
            bus.spi_sclk = 1'b1;
            bus.spi_mosi = mo[n-1-i];
            cyc(H);
            mi = {mi[62:0], bus.spi_miso};
            if (bus.spi_miso_oe) oe_hi++;
            bus.spi_sclk = 1'b0;
            cyc(H);
        end
    endtask

    task automatic frame(input int n, input logic [63:0] mo,
                         output logic [63:0] mi, output int oe_hi, output int bc);
        bus.spi_cs_n = 1'b0;
        cyc(H);
        clk_bits(n, mo, mi, oe_hi);
        cyc(2);
        bc = int'(bus.bit_count);
        bus.spi_cs_n = 1'b1;
        cyc(2 * H);
    endtask

    logic [63:0] mi;
    int          oe_hi, bc, r0, f0, u0;
    logic [31:0] tx_w [3];
    logic [31:0] mo_w [3];

    initial begin
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;

        // Reset values
        cyc(3);
        chk("rst_miso",     bus.spi_miso, 0);
        chk("rst_miso_oe",  bus.spi_miso_oe, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_rx_data",  bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_ferr",     bus.frame_error, 0);
        chk("rst_underrun", bus.tx_underrun, 0);
        chk("rst_bit_count", bus.bit_count, 0);
        reset = 1'b0;
        cyc(8);

        // Full frame
        r0 = n_rxv; f0 = n_ferr; u0 = n_und;
        load_tx(32'hA5C3_0F81);
        chk("full_tx_ready_low", bus.tx_ready, 0);
        frame(32, 64'h1234_ABCD, mi, oe_hi, bc);
        chk("full_miso",     mi, 64'hA5C3_0F81);
        chk("full_oe",       oe_hi, 32);
        chk("full_bc_end",   bc, 32);
        chk("full_rx_data",  bus.rx_data, 32'h1234_ABCD);
        chk("full_rx_valid", n_rxv - r0, 1);
        chk("full_ferr",     n_ferr - f0, 0);
        chk("full_underrun", n_und - u0, 0);
        chk("full_bc_idle",  bus.bit_count, 0);
        chk("full_oe_off",   bus.spi_miso_oe, 0);
        chk("full_tx_ready", bus.tx_ready, 1);

        // Underrun, with a handshake on the synchronized CS_N fall cycle
        r0 = n_rxv; u0 = n_und;
        bus.spi_cs_n = 1'b0;
        cyc(2);
        bus.tx_data  = 32'hDEAD_BEEF;
        bus.tx_valid = 1'b1;
        cyc(1);
        bus.tx_valid = 1'b0;
        cyc(H - 3);
        chk("und_tx_ready_low", bus.tx_ready, 0);
        clk_bits(32, 64'h0F0F_3C3C, mi, oe_hi);
        cyc(2);
        bus.spi_cs_n = 1'b1;
        cyc(2 * H);
        chk("und_miso",     mi, 0);
        chk("und_pulse",    n_und - u0, 1);
        chk("und_rx_data",  bus.rx_data, 32'h0F0F_3C3C);
        chk("und_rx_valid", n_rxv - r0, 1);
        chk("und_buf_kept", bus.tx_ready, 0);

        // Held word goes out in the next frame
        u0 = n_und;
        frame(32, 64'h7654_3210, mi, oe_hi, bc);
        chk("next_miso",     mi, 64'hDEAD_BEEF);
        chk("next_underrun", n_und - u0, 0);
        chk("next_tx_ready", bus.tx_ready, 1);

        // Short frame: 20 bits
        r0 = n_rxv; f0 = n_ferr;
        load_tx(32'hF0F0_1234);
        frame(20, 64'h000F_FFFF, mi, oe_hi, bc);
        chk("short_miso",     mi, 64'hF0F01);
        chk("short_bc_end",   bc, 20);
        chk("short_ferr",     n_ferr - f0, 1);
        chk("short_rx_valid", n_rxv - r0, 0);
        chk("short_rx_data",  bus.rx_data, 32'h7654_3210);
        chk("short_bc_idle",  bus.bit_count, 0);

        // Long frame: 34 bits
        r0 = n_rxv; f0 = n_ferr;
        load_tx(32'h8000_0001);
        frame(34, {30'b0, 32'hCAFE_F00D, 2'b11}, mi, oe_hi, bc);
        chk("long_miso",     mi, {30'b0, 32'h8000_0001, 2'b00});
        chk("long_bc_sat",   bc, 32);
        chk("long_rx_data",  bus.rx_data, 32'hCAFE_F00D);
        chk("long_rx_valid", n_rxv - r0, 1);
        chk("long_ferr",     n_ferr - f0, 0);

        // Reset mid-frame at bit 10
        load_tx(32'h1122_3344);
        bus.spi_cs_n = 1'b0;
        cyc(H);
        clk_bits(10, 64'h3FF, mi, oe_hi);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        r0 = n_rxv; f0 = n_ferr;
        clk_bits(22, 64'h2A_AAAA, mi, oe_hi);
        chk("rstmid_oe_during", oe_hi, 0);
        chk("rstmid_miso", mi, 0);
        cyc(2);
        bus.spi_cs_n = 1'b1;
        cyc(2 * H);
        chk("rstmid_rx_valid", n_rxv - r0, 0);
        chk("rstmid_ferr",     n_ferr - f0, 0);
        chk("rstmid_rx_data",  bus.rx_data, 0);
        chk("rstmid_tx_ready", bus.tx_ready, 1);

        r0 = n_rxv; u0 = n_und;
        load_tx(32'h0BAD_CAFE);
        frame(32, 64'h5A5A_C3C3, mi, oe_hi, bc);
        chk("postrst_miso",     mi, 64'h0BAD_CAFE);
        chk("postrst_rx_data",  bus.rx_data, 32'h5A5A_C3C3);
        chk("postrst_rx_valid", n_rxv - r0, 1);
        chk("postrst_underrun", n_und - u0, 0);

        // Back-to-back frames, one SCLK period of CS_N high between them
        tx_w[0] = 32'h0102_0304; mo_w[0] = 32'hFFFF_0000;
        tx_w[1] = 32'hF0E0_D0C0; mo_w[1] = 32'h00FF_00FF;
        tx_w[2] = 32'h1357_9BDF; mo_w[2] = 32'h89AB_CDEF;
        r0 = n_rxv; u0 = n_und;
        for (int k = 0; k < 3; k++) begin
            load_tx(tx_w[k]);
            frame(32, {32'b0, mo_w[k]}, mi, oe_hi, bc);
            chk("b2b_miso",    mi, {32'b0, tx_w[k]});
            chk("b2b_rx_data", bus.rx_data, mo_w[k]);
        end
        chk("b2b_rx_valid", n_rxv - r0, 3);
        chk("b2b_underrun", n_und - u0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
